// File: rtl/sm_operand_pair.sv
// sm_operand_pair: converts two's-complement words to sign-magnitude and presents consecutive words as an (A, B) pair
module sm_operand_pair #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic [N-1:0] i_in_data,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    output logic [N-1:0] o_op_a,
    output logic [N-1:0] o_op_b,
    output logic         o_ovf_a,
    output logic         o_ovf_b,
    output logic         o_out_valid,
    input  logic         i_out_ready
);
    typedef enum logic [1:0] {S_A, S_B, S_OUT} state_t;
    state_t       r_state, w_next;
    logic [N-1:0] r_op_a, r_op_b, w_conv;
    logic [N-2:0] w_mag;
    logic         r_ovf_a, r_ovf_b, r_out_valid;
    logic         w_acc_in, w_acc_out, w_load_a, w_load_b, w_ovf;

    assign w_mag      = ~i_in_data[N-2:0] + (N-1)'(1);
    assign w_ovf      = i_in_data == {1'b1, {(N-1){1'b0}}};
    assign w_conv     = !i_in_data[N-1] ? i_in_data : w_ovf ? '1 : {1'b1, w_mag};
    assign o_in_ready = (r_state != S_OUT) | i_out_ready;
    assign w_acc_in   = i_in_valid & o_in_ready;
    assign w_acc_out  = r_out_valid & i_out_ready;
    assign o_op_a      = r_op_a;
    assign o_op_b      = r_op_b;
    assign o_ovf_a     = r_ovf_a;
    assign o_ovf_b     = r_ovf_b;
    assign o_out_valid = r_out_valid;

    // next state and operand load enables; flush wins over any handshake
    always_comb begin
        w_next   = r_state;
        w_load_a = 1'b0;
        w_load_b = 1'b0;
        case (r_state)
            S_A: begin
                w_load_a = w_acc_in;
                w_next   = w_acc_in ? S_B : S_A;
            end
            S_B: begin
                w_load_b = w_acc_in;
                w_next   = w_acc_in ? S_OUT : S_B;
            end
            S_OUT: begin
                w_load_a = w_acc_in;
                w_next   = !w_acc_out ? S_OUT : w_acc_in ? S_B : S_A;
            end
            default: w_next = S_A;
        endcase
        if (i_flush) begin
            w_next   = S_A;
            w_load_a = 1'b0;
            w_load_b = 1'b0;
        end
    end

    // state, pair registers and registered out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_A;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_ovf_a     <= 1'b0;
            r_ovf_b     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= w_next == S_OUT;
            if (w_load_a) begin
                r_op_a  <= w_conv;
                r_ovf_a <= w_ovf;
            end
            if (w_load_b) begin
                r_op_b  <= w_conv;
                r_ovf_b <= w_ovf;
            end
        end
    end
endmodule

// File: tb/tb_sm_operand_pair.sv
// tb_sm_operand_pair: directed and random checks of the operand pairing stage against a reference model and scoreboard
module tb_sm_operand_pair;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] op_a, op_b;
    logic       ovf_a, ovf_b, out_valid;
    logic       out_ready = 1'b0;

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_acc = 0;
    int         m_state = 0;
    logic [7:0] m_a;
    logic       m_ova;
    logic [17:0] sb[$];
    logic [17:0] junk;

    sm_operand_pair #(.N(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_data(in_data),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .o_op_a(op_a), .o_op_b(op_b),
        .o_ovf_a(ovf_a), .o_ovf_b(ovf_b), .o_out_valid(out_valid), .i_out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] ref_conv(input logic [7:0] x);
        int v;
        v = (x >= 8'h80) ? int'(x) - 256 : int'(x);
        if (v >= 0) return {x, 1'b0};
        if (v == -128) return {8'hFF, 1'b1};
        v = -v;
        return {1'b1, v[6:0], 1'b0};
    endfunction

    task automatic set_in(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
        in_valid = v;
        in_data = d;
        out_ready = ordy;
        flush = fl;
        #1;
    endtask

    task automatic tick();
        logic       ai, ao;
        logic [8:0] c;
        ai = in_valid & ((m_state != 2) | out_ready);
        ao = (m_state == 2) & out_ready;
        c = ref_conv(in_data);
        if (ai) n_acc++;
        if (flush) begin
            if (m_state == 2) junk = sb.pop_front();
            m_state = 0;
        end else if (m_state == 0 && ai) begin
            {m_a, m_ova} = c;
            m_state = 1;
        end else if (m_state == 1 && ai) begin
            sb.push_back({m_a, m_ova, c});
            m_state = 2;
        end else if (m_state == 2 && ao) begin
            junk = sb.pop_front();
            if (ai) begin
                {m_a, m_ova} = c;
                m_state = 1;
            end else m_state = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_chk++; if ({op_a, op_b, ovf_a, ovf_b} !== 18'h0) begin n_fail++; $display("FAIL reset_ops got %h/%h/%b/%b exp 0", op_a, op_b, ovf_a, ovf_b); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        set_in(1, 8'h05, 1, 0); tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_after_a got %b exp 0", out_valid); end
        set_in(1, 8'hFD, 1, 0); tick();
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %b exp 1", out_valid); end
        n_chk++; if (op_a !== 8'h05 || op_b !== 8'h83) begin n_fail++; $display("FAIL t1_ops got %h/%h exp 05/83", op_a, op_b); end
        set_in(0, 8'h00, 1, 0);
        n_chk++; if (sb.size() == 0 || {op_a, ovf_a, op_b, ovf_b} !== sb[0]) begin n_fail++; $display("FAIL t1_sb got %h exp %h", {op_a, ovf_a, op_b, ovf_b}, sb.size() ? sb[0] : 18'h0); end
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_one_cycle got %b exp 0", out_valid); end
    endtask

    task automatic test_conv();
        set_in(1, 8'h80, 1, 0); tick();
        set_in(1, 8'h00, 1, 0); tick();
        n_chk++; if ({op_a, ovf_a, op_b, ovf_b} !== {8'hFF, 1'b1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL t2_sat got %h/%b/%h/%b exp ff/1/00/0", op_a, ovf_a, op_b, ovf_b); end
        set_in(1, 8'hFF, 1, 0);
        n_chk++; if (sb.size() == 0 || {op_a, ovf_a, op_b, ovf_b} !== sb[0]) begin n_fail++; $display("FAIL t2_sb got %h exp %h", {op_a, ovf_a, op_b, ovf_b}, sb.size() ? sb[0] : 18'h0); end
        tick();
        set_in(1, 8'h7F, 1, 0); tick();
        n_chk++; if ({op_a, ovf_a, op_b, ovf_b} !== {8'h81, 1'b0, 8'h7F, 1'b0}) begin n_fail++; $display("FAIL t2_ff7f got %h/%b/%h/%b exp 81/0/7f/0", op_a, ovf_a, op_b, ovf_b); end
        set_in(0, 8'h00, 1, 0); tick();
    endtask

    task automatic test_stall();
        set_in(1, 8'h01, 1, 0); tick();
        set_in(1, 8'h02, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 8'h55, 0, 0);
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t3_in_ready got %b exp 0", in_ready); end
            tick();
            n_chk++; if ({out_valid, op_a, op_b} !== {1'b1, 8'h01, 8'h02}) begin n_fail++; $display("FAIL t3_hold got %b/%h/%h exp 1/01/02", out_valid, op_a, op_b); end
        end
        set_in(1, 8'h10, 1, 0);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL t3_ready_release got %b exp 1", in_ready); end
        n_chk++; if (sb.size() == 0 || {op_a, ovf_a, op_b, ovf_b} !== sb[0]) begin n_fail++; $display("FAIL t3_sb got %h exp %h", {op_a, ovf_a, op_b, ovf_b}, sb.size() ? sb[0] : 18'h0); end
        tick();
        n_chk++; if ({out_valid, op_a} !== {1'b0, 8'h10}) begin n_fail++; $display("FAIL t3_retire got %b/%h exp 0/10", out_valid, op_a); end
        set_in(1, 8'h20, 1, 0); tick();
        n_chk++; if ({out_valid, op_a, op_b} !== {1'b1, 8'h10, 8'h20}) begin n_fail++; $display("FAIL t3_next_pair got %b/%h/%h exp 1/10/20", out_valid, op_a, op_b); end
        set_in(0, 8'h00, 1, 0); tick();
    endtask

    task automatic test_flush();
        set_in(1, 8'h22, 1, 0); tick();
        set_in(1, 8'h33, 1, 1); tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t4_flush_valid got %b exp 0", out_valid); end
        set_in(1, 8'h01, 1, 0); tick();
        set_in(1, 8'h02, 1, 0); tick();
        n_chk++; if ({out_valid, op_a, op_b} !== {1'b1, 8'h01, 8'h02}) begin n_fail++; $display("FAIL t4_pair got %b/%h/%h exp 1/01/02", out_valid, op_a, op_b); end
        set_in(1, 8'h44, 1, 1); tick();
        n_chk++; if (out_valid !== 1'b0 || sb.size() != 0) begin n_fail++; $display("FAIL t4_flush_pair got %b/%0d exp 0/0", out_valid, sb.size()); end
        set_in(0, 8'h00, 1, 0); tick();
    endtask

    task automatic test_async_reset();
        set_in(1, 8'h07, 1, 0); tick();
        set_in(0, 8'h00, 1, 0);
        rst_n = 1'b0;
        #1;
        n_chk++; if ({out_valid, op_a} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL t5_sb_reset got %b/%h exp 0/00", out_valid, op_a); end
        m_state = 0; sb.delete();
        @(posedge clk); #1; rst_n = 1'b1;
        set_in(1, 8'h03, 1, 0); tick();
        set_in(1, 8'h04, 0, 0); tick();
        rst_n = 1'b0;
        #1;
        n_chk++; if ({out_valid, op_a, op_b, ovf_a, ovf_b} !== 19'h0) begin n_fail++; $display("FAIL t5_out_reset got %b/%h/%h exp 0/00/00", out_valid, op_a, op_b); end
        m_state = 0; sb.delete();
        @(posedge clk); #1; rst_n = 1'b1;
        set_in(1, 8'hFE, 1, 0); tick();
        set_in(1, 8'h09, 1, 0); tick();
        n_chk++; if ({out_valid, op_a, op_b} !== {1'b1, 8'h82, 8'h09}) begin n_fail++; $display("FAIL t5_fresh got %b/%h/%h exp 1/82/09", out_valid, op_a, op_b); end
        set_in(0, 8'h00, 1, 0); tick();
    endtask

    task automatic test_random();
        int start, cyc, pairs;
        logic [7:0] d;
        start = n_acc;
        cyc = 0;
        pairs = 0;
        while (n_acc - start < 1000 && cyc < 20000) begin
            d = ($urandom_range(0, 19) == 0) ? 8'h80 : 8'($urandom);
            set_in(n_acc - start < 1000 && $urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, 0);
            n_chk++; if (in_ready !== ((m_state != 2) | out_ready)) begin n_fail++; $display("FAIL t6_in_ready got %b state %0d", in_ready, m_state); end
            n_chk++; if (out_valid !== (m_state == 2)) begin n_fail++; $display("FAIL t6_out_valid got %b state %0d", out_valid, m_state); end
            if (out_valid && out_ready) begin
                pairs++;
                n_chk++; if (sb.size() == 0 || {op_a, ovf_a, op_b, ovf_b} !== sb[0]) begin n_fail++; $display("FAIL t6_pair got %h exp %h", {op_a, ovf_a, op_b, ovf_b}, sb.size() ? sb[0] : 18'h0); end
            end
            tick();
            cyc++;
        end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 8'h00, 1, 0);
            if (out_valid) begin
                pairs++;
                n_chk++; if (sb.size() == 0 || {op_a, ovf_a, op_b, ovf_b} !== sb[0]) begin n_fail++; $display("FAIL t6_drain got %h exp %h", {op_a, ovf_a, op_b, ovf_b}, sb.size() ? sb[0] : 18'h0); end
            end
            tick();
        end
        n_chk++; if (pairs != 500 || cyc >= 20000) begin n_fail++; $display("FAIL t6_count got %0d pairs in %0d cycles exp 500", pairs, cyc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conv();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
